// File: rtl/subparser_dispatch_pkg.sv
// rtl/subparser_dispatch_pkg.sv - shared types and helpers for the subparser dispatcher
//
// Contents:
//   dispatch_state_t  dispatcher FSM states
//   SEL_INVALID_FLAG  value of the sel MSB that always marks an out-of-range index
//   idx_width()       width of the registered subparser index
package subparser_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    FINISH
  } dispatch_state_t;

  // sel carries one bit more than the index; with that MSB set the request
  // can never address an attached subparser.
  localparam logic SEL_INVALID_FLAG = 1'b1;

  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// rtl/dispatch_watchdog.sv - saturating cycle counter that flags an overlong dispatch
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       return the count to zero (dominates enable)
//   enable      count this cycle
//   expired     count has reached LIMIT; never asserted when LIMIT is 0
module dispatch_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count;
  logic         at_limit;

  // Holding at LIMIT makes the counter saturate; with LIMIT 0 it never leaves zero.
  assign at_limit = (count == LIMIT_W);
  assign expired  = (LIMIT != 0) && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/subparser_dispatcher.sv
// rtl/subparser_dispatcher.sv - runs one selected subparser per command over a shared byte reader
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   trigger, sel, rdy        dispatch request from the parser FSM; sel captured on trigger
//   done, success, timeout   one-cycle completion pulse and result flags held until next trigger
//   sp_trigger/done/rdy/success  per-subparser start handshake and result
//   sp_rd_trigger/rd_done/rd_rdy  per-subparser read path, only the active one is connected
//   sp_is_empty              is_empty broadcast to every subparser
//   rd_trigger, rd_done, rd_rdy, is_empty  shared upstream byte reader
module subparser_dispatcher
  import subparser_dispatch_pkg::*;
#(
  parameter int NUM_SUBPARSERS = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int SEL_W = $clog2(NUM_SUBPARSERS) + 1,
  localparam int IDX_W = idx_width(NUM_SUBPARSERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [SEL_W-1:0]          sel,
  output logic                      rdy,
  output logic                      done,
  output logic                      success,
  output logic                      timeout,
  output logic [NUM_SUBPARSERS-1:0] sp_trigger,
  input  logic [NUM_SUBPARSERS-1:0] sp_done,
  input  logic [NUM_SUBPARSERS-1:0] sp_rdy,
  input  logic [NUM_SUBPARSERS-1:0] sp_success,
  input  logic [NUM_SUBPARSERS-1:0] sp_rd_trigger,
  output logic [NUM_SUBPARSERS-1:0] sp_rd_done,
  output logic [NUM_SUBPARSERS-1:0] sp_rd_rdy,
  output logic [NUM_SUBPARSERS-1:0] sp_is_empty,
  output logic                      rd_trigger,
  input  logic                      rd_done,
  input  logic                      rd_rdy,
  input  logic                      is_empty
);

  localparam logic [SEL_W-1:0] NUM_SEL = SEL_W'(NUM_SUBPARSERS);

  dispatch_state_t  state, state_next;
  logic [IDX_W-1:0] idx;
  logic             rd_pending;
  logic             wd_expired;
  logic             sel_invalid;
  logic             rd_fire;
  logic             pend_after;
  logic             abort;

  assign sel_invalid = (sel[SEL_W-1] == SEL_INVALID_FLAG) || (sel >= NUM_SEL);

  // Built from the routed inputs rather than rd_trigger so the FSM block
  // below does not read back one of its own outputs.
  assign rd_fire    = (state == RUN) && sp_rd_trigger[idx] && rd_rdy;
  // A request accepted on the expiry cycle itself must still be drained.
  assign pend_after = rd_fire || (rd_pending && !rd_done);

  assign rdy         = (state == IDLE);
  assign done        = (state == FINISH);
  assign sp_is_empty = {NUM_SUBPARSERS{is_empty}};

  dispatch_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == ARM) || (state == RUN)),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    abort         = 1'b0;
    sp_trigger    = '0;
    sp_rd_done    = '0;
    sp_rd_rdy     = '0;
    rd_trigger    = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = sel_invalid ? FINISH : ARM;
        end
      end
      ARM: begin
        // Once expired, the subparser is no longer started.
        if (wd_expired) begin
          abort      = 1'b1;
          state_next = pend_after ? DRAIN : FINISH;
        end else begin
          sp_trigger[idx] = sp_rdy[idx];
          if (sp_rdy[idx]) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        rd_trigger      = sp_rd_trigger[idx];
        sp_rd_done[idx] = rd_done;
        sp_rd_rdy[idx]  = rd_rdy;
        // Normal completion wins over a watchdog expiry on the same cycle.
        if (sp_done[idx]) begin
          state_next = FINISH;
        end else if (wd_expired) begin
          abort      = 1'b1;
          state_next = pend_after ? DRAIN : FINISH;
        end
      end
      DRAIN: begin
        // The outstanding read is absorbed here, never shown to the subparser.
        if (rd_done) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      success <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if ((state == IDLE) && trigger) begin
        idx     <= sel[IDX_W-1:0];
        success <= 1'b0;
        timeout <= 1'b0;
      end
      if ((state == RUN) && sp_done[idx]) begin
        success <= sp_success[idx];
      end else if (abort) begin
        timeout <= 1'b1;
        success <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
    end else if (rd_fire) begin
      rd_pending <= 1'b1;
    end else if (rd_done) begin
      rd_pending <= 1'b0;
    end
  end

endmodule

// File: doc/subparser_dispatcher.md
Name: subparser_dispatcher

Overview:
- Sequences one of NUM_SUBPARSERS subparsers per parse command.
- Triggers the selected subparser and shares the single upstream byte reader with it, gating all other subparsers off the reader.
- Collects the done/success result and applies a watchdog timeout.
- Sits between the top-level parser FSM, which selects a subparser by command letter, and the subparser bank.

Parameters:
- NUM_SUBPARSERS, 4, number of attached subparsers (2..16).
- TIMEOUT_CYCLES, 4096, maximum cycles in ARM+RUN before abort. 0 disables the watchdog.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- trigger  input  1  start a dispatch; sampled only when rdy=1
- sel  input  $clog2(NUM_SUBPARSERS)+1  subparser index, captured on trigger
- rdy  output  1  dispatcher idle and accepts trigger
- done  output  1  one-cycle pulse: dispatch finished
- success  output  1  result of last dispatch; valid from done, held until next trigger
- timeout  output  1  last dispatch aborted by watchdog; held like success
- sp_trigger  output  NUM_SUBPARSERS  per-subparser trigger pulse
- sp_done  input  NUM_SUBPARSERS  per-subparser done
- sp_rdy  input  NUM_SUBPARSERS  per-subparser ready
- sp_success  input  NUM_SUBPARSERS  per-subparser success
- sp_rd_trigger  input  NUM_SUBPARSERS  per-subparser read request
- sp_rd_done  output  NUM_SUBPARSERS  read done, routed to the active subparser only
- sp_rd_rdy  output  NUM_SUBPARSERS  reader ready, routed to the active subparser only
- sp_is_empty  output  NUM_SUBPARSERS  is_empty broadcast to all subparsers
- rd_trigger  output  1  shared reader request
- rd_done  input  1  shared reader done
- rd_rdy  input  1  shared reader ready
- is_empty  input  1  shared reader has no more data

Behaviour:
- States: IDLE, ARM, RUN, DRAIN, FINISH.
- Reset (async): state IDLE, idx 0, done/success/timeout 0, rd_pending 0, watchdog 0. rdy = (state==IDLE), so rdy reads 1 during and after reset. All sp_* outputs are 0 except sp_is_empty, which follows is_empty.
- IDLE:
  - trigger=1 captures sel into idx and clears success/timeout.
  - If sel >= NUM_SUBPARSERS, go to FINISH with success=0 and no subparser touched.
  - Otherwise go to ARM.
  - trigger while not IDLE is ignored.
- ARM:
  - sp_trigger[idx] = sp_rdy[idx], combinational, so at most one cycle.
  - When sp_rdy[idx]=1, go to RUN on the next edge.
- RUN:
  - rd_trigger = sp_rd_trigger[idx]
  - sp_rd_done[idx] = rd_done
  - sp_rd_rdy[idx] = rd_rdy
  - All other sp_rd_* are 0.
  - rd_pending sets when rd_trigger & rd_rdy, and clears on rd_done (set wins only if both occur on a fresh request).
  - sp_done[idx]=1 latches success = sp_success[idx] and moves to FINISH.
  - Inputs from non-selected subparsers are ignored in all states.
- Watchdog:
  - Counts each cycle in ARM/RUN.
  - On reaching TIMEOUT_CYCLES: timeout=1, success=0, then DRAIN if rd_pending, else FINISH.
  - sp_done on the same cycle as expiry takes priority: normal completion.
- DRAIN:
  - rd_trigger is forced to 0.
  - Wait for rd_done, which is not forwarded to the subparser, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Latency:
  - trigger at T gives ARM at T+1.
  - With sp_rdy high, sp_trigger is asserted at T+1 and RUN starts at T+2.
  - sp_done at D gives done at D+1 and rdy at D+2.
  - Invalid sel: trigger at T gives done at T+1.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Package subparser_dispatch_pkg holds:
  - the dispatch_state_t enum (IDLE, ARM, RUN, DRAIN, FINISH);
  - the function computing the idx width from NUM_SUBPARSERS;
  - the constant SEL_INVALID_FLAG.
- One sub-module: dispatch_watchdog, a parameterised saturating counter with clear/enable/expired outputs.
- Read routing stays inline as combinational muxes in the top module.

Test Plan:
1. NUM=4, sel=2, sp_rdy[2]=1 → sp_trigger=4'b0100 for 1 cycle. Subparser does 3 reads (rd_done after 2 cycles each); sp_rd_done only on bit 2. sp_done[2] with sp_success=1 → done pulse, success=1, timeout=0.
2. sel=1, sp_success[1]=0 → done, success=0. sp_rd_trigger[0] and [3] toggled throughout → rd_trigger never follows them.
3. sel=5 (invalid) → done one cycle after trigger, success=0, sp_trigger never asserted.
4. TIMEOUT_CYCLES=16, subparser 0 never sends done, read outstanding at expiry → DRAIN held until rd_done; then done, timeout=1, success=0; sp_rd_done[0] stays 0.
5. sp_rdy[3]=0 for 5 cycles after trigger → ARM holds, sp_trigger[3] asserted only on the first cycle sp_rdy[3]=1. A second trigger during RUN is ignored.
6. reset asserted mid-RUN with rd_pending=1 → outputs cleared immediately; rdy=1 after release; a fresh dispatch with sel=0 completes normally.
